wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entry count, power of two, 2..64.
REQ-002 Parameter PC_START, default 32'd12: lowest P_C at which write-backs are captured.
REQ-003 reloj  input  1  single clock; all state updates on the rising edge.
REQ-004 resetM  input  1  reset, synchronous, active-high.
REQ-005 P_C  input  32  current program counter from the processor.
REQ-006 REG_WR  input  1  register-file write enable, active-low (0 = write this cycle).
REQ-007 DIR_WRA  input  5  write-back destination register.
REQ-008 DI_banco  input  32  write-back data from the ALU path.
REQ-009 DO_D  input  32  write-back data from the memory path.
REQ-010 trc_valid  output  1  a trace entry is presented.
REQ-011 trc_ready  input  1  consumer accepts the presented entry.
REQ-012 trc_dir  output  5  register number of the presented entry.
REQ-013 trc_data  output  32  data of the presented entry.
REQ-014 trc_seq  output  8  capture sequence number of the presented entry.
REQ-015 shadow_addr  input  5  shadow register-file read address.
REQ-016 shadow_data  output  32  shadow register-file read data, registered.
REQ-017 count  output  7  current FIFO occupancy, 0..DEPTH.
REQ-018 ovf  output  1  sticky overflow flag.
REQ-019 drop_cnt  output  8  count of dropped captures, saturating.

Function
REQ-020 The block SHALL assert a capture when P_C >= PC_START (unsigned), REG_WR == 0, DIR_WRA != 0 and resetM == 0.
REQ-021 The capture data SHALL be DI_banco | DO_D (bitwise OR).
REQ-022 Each capture SHALL be assigned the current 8-bit sequence counter value, which then increments by 1 and wraps 255 -> 0, whether or not the entry is stored.
REQ-023 The FIFO SHALL be first-word-fall-through: trc_valid = (count != 0), and trc_dir/trc_data/trc_seq show the oldest entry.
REQ-024 A pop SHALL occur on a cycle where trc_valid && trc_ready; the next entry, if any, SHALL appear on the following cycle.
REQ-025 A captured entry SHALL appear on trc_* no earlier than one cycle after its capture edge; there is no same-cycle bypass.
REQ-026 When count < DEPTH, a capture SHALL be stored.
REQ-027 When count == DEPTH and a pop occurs in the same cycle, the capture SHALL be stored and count SHALL remain DEPTH.
REQ-028 When count == DEPTH and no pop occurs, the capture SHALL be dropped, ovf SHALL be set, and drop_cnt SHALL increment, saturating at 255.
REQ-029 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-030 trc_ready while count == 0 SHALL have no effect.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 The shadow register file (32 x 32) SHALL write capture data to entry DIR_WRA on every capture, including dropped ones; entry 0 SHALL always read 0.
REQ-033 shadow_data SHALL equal the entry at shadow_addr one cycle after sampling, with write-first behaviour: a same-cycle capture to that address returns the new data.
REQ-034 ovf SHALL clear only on reset.

Reset
REQ-035 While resetM is high at a rising edge, the block SHALL clear FIFO pointers, count, sequence counter, ovf, drop_cnt, the shadow_data register and all 32 shadow entries to 0.
REQ-036 While resetM is high, trc_valid, trc_dir, trc_data, trc_seq and count SHALL read 0.
REQ-037 Reset asserted mid-operation SHALL discard all stored entries; a pop or capture in that cycle SHALL have no effect.

Structure
REQ-038 A shared package wb_trace_pkg SHALL hold the DEPTH and PC_START defaults, the entry width (5+32+8 = 45) and the entry field offsets.
REQ-039 FIFO storage and pointers SHALL be a sub-module sync_fifo (parameterised width/depth, with full/empty/count outputs); capture logic, sequence counter, statistics and the shadow file SHALL reside in wb_trace_buffer.

Verification
REQ-040 Stimulus: reset; P_C=8, REG_WR=0, DIR_WRA=3 -> no capture, count=0. Then P_C=12, DIR_WRA=3, DI_banco=32'h0000_00F0, DO_D=32'h0000_000F -> trc_data=32'h0000_00FF, trc_dir=3, trc_seq=0 on the next cycle.
REQ-041 Stimulus: DIR_WRA=0 with REG_WR=0, and DIR_WRA=5 with REG_WR=1 -> no capture, sequence counter unchanged.
REQ-042 Stimulus: 10 consecutive captures with trc_ready=0 and DEPTH=8 -> count=8, ovf=1, drop_cnt=2. Draining then yields seq 0..7 in order.
REQ-043 Stimulus: FIFO full, capture with trc_ready=1 in the same cycle -> count stays 8, ovf stays 0, the new entry is last out.
REQ-044 Stimulus: capture to register 7 with data 32'hDEAD_BEEF while shadow_addr=7 -> shadow_data=32'hDEAD_BEEF on the next cycle. Stimulus: reset asserted with 4 entries queued -> count=0, trc_valid=0, shadow entry 7 reads 0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared constants and entry layout for the write-back trace buffer.
// A FIFO entry packs {dir, data, seq} into one 45-bit word.
package wb_trace_pkg;

  localparam int          DEPTH_DEF    = 8;
  localparam logic [31:0] PC_START_DEF = 32'd12;

  localparam int DIR_W  = 5;
  localparam int DATA_W = 32;
  localparam int SEQ_W  = 8;
  localparam int ENTRY_W = DIR_W + DATA_W + SEQ_W;  // 45

  // Field offsets inside a packed entry (LSB positions).
  localparam int SEQ_LSB  = 0;
  localparam int DATA_LSB = SEQ_LSB + SEQ_W;   // 8
  localparam int DIR_LSB  = DATA_LSB + DATA_W; // 40

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [DIR_W-1:0]  dir,
    input logic [DATA_W-1:0] data,
    input logic [SEQ_W-1:0]  seq
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[DIR_LSB  +: DIR_W]  = dir;
    e[DATA_LSB +: DATA_W] = data;
    e[SEQ_LSB  +: SEQ_W]  = seq;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. o_rdata always shows the oldest
// entry; a push that finds the FIFO full is accepted only when a pop happens
// in the same cycle. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter  int WIDTH = 45,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures register-file writes above a PC
// threshold, tags them with a sequence number, queues them for a consumer
// and mirrors them into a 32-entry shadow register file.
//
// Trace handshake: trc_valid is high whenever an entry is held; the entry on
// trc_dir/trc_data/trc_seq is stable until the cycle where trc_valid and
// trc_ready are both high at a rising edge, which consumes it; the next entry
// is shown from the following cycle. trc_ready with nothing held is ignored.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] PC_START = PC_START_DEF
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [31:0] P_C,
  input  logic        REG_WR,
  input  logic [4:0]  DIR_WRA,
  input  logic [31:0] DI_banco,
  input  logic [31:0] DO_D,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [4:0]  trc_dir,
  output logic [31:0] trc_data,
  output logic [7:0]  trc_seq,
  input  logic [4:0]  shadow_addr,
  output logic [31:0] shadow_data,
  output logic [6:0]  count,
  output logic        ovf,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]         r_seq;
  logic               r_ovf;
  logic [7:0]         r_drop;
  logic [31:0]        r_shadow [32];
  logic [31:0]        r_shadow_data;

  logic               w_capture;
  logic [31:0]        w_cap_data;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic               w_drop;
  logic               w_show;

  assign w_capture  = (P_C >= PC_START) && !REG_WR && (DIR_WRA != 5'd0) && !resetM;
  assign w_cap_data = DI_banco | DO_D;
  assign w_wr_entry = pack_entry(DIR_WRA, w_cap_data, r_seq);
  // Full means non-empty, so a ready consumer always frees a slot this cycle.
  assign w_drop     = w_capture && w_full && !trc_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (reloj),
    .i_rst   (resetM),
    .i_push  (w_capture),
    .i_wdata (w_wr_entry),
    .i_pop   (trc_ready && !resetM),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Outputs are forced quiet while reset is held, even before its first edge.
  assign w_show    = !w_empty && !resetM;
  assign trc_valid = w_show;
  assign trc_dir   = w_show ? w_rd_entry[DIR_LSB  +: DIR_W]  : '0;
  assign trc_data  = w_show ? w_rd_entry[DATA_LSB +: DATA_W] : '0;
  assign trc_seq   = w_show ? w_rd_entry[SEQ_LSB  +: SEQ_W]  : '0;
  assign count     = resetM ? 7'd0 : 7'(w_count);

  assign ovf         = r_ovf;
  assign drop_cnt    = r_drop;
  assign shadow_data = r_shadow_data;

  // Sequence numbering and drop statistics.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_seq  <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_capture) r_seq <= r_seq + 8'd1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Shadow register file: every capture lands here, stored or dropped.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
    end else if (w_capture) begin
      r_shadow[DIR_WRA] <= w_cap_data;
    end
  end

  // Registered shadow read with write-first forwarding of a same-cycle capture.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_shadow_data <= '0;
    end else if (w_capture && (DIR_WRA == shadow_addr)) begin
      r_shadow_data <= w_cap_data;
    end else begin
      r_shadow_data <= r_shadow[shadow_addr];
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed vector table, hand-written corner
// sequences and a long randomized run, all scored against a queue-based model.
module tb_wb_trace_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] PC_START = 32'd12;

  // ---------------- clock / reset / DUT ----------------
  logic        reloj = 1'b0;
  logic        resetM;
  logic [31:0] P_C;
  logic        REG_WR;
  logic [4:0]  DIR_WRA;
  logic [31:0] DI_banco;
  logic [31:0] DO_D;
  logic        trc_valid;
  logic        trc_ready;
  logic [4:0]  trc_dir;
  logic [31:0] trc_data;
  logic [7:0]  trc_seq;
  logic [4:0]  shadow_addr;
  logic [31:0] shadow_data;
  logic [6:0]  count;
  logic        ovf;
  logic [7:0]  drop_cnt;

  always #5 reloj = ~reloj;

  wb_trace_buffer #(.DEPTH(DEPTH), .PC_START(PC_START)) dut (
    .reloj       (reloj),
    .resetM      (resetM),
    .P_C         (P_C),
    .REG_WR      (REG_WR),
    .DIR_WRA     (DIR_WRA),
    .DI_banco    (DI_banco),
    .DO_D        (DO_D),
    .trc_valid   (trc_valid),
    .trc_ready   (trc_ready),
    .trc_dir     (trc_dir),
    .trc_data    (trc_data),
    .trc_seq     (trc_seq),
    .shadow_addr (shadow_addr),
    .shadow_data (shadow_data),
    .count       (count),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  // Expected FIFO contents, oldest first, each word {dir[44:40], data[39:8], seq[7:0]}.
  logic [44:0] exp_q[$];
  logic [7:0]  m_seq;
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic [31:0] m_sh [32];
  logic [31:0] m_shd;
  logic        m_rst;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the rules of the block.
  task automatic model_step(input logic rst, input logic [31:0] pc, input logic wr,
                            input logic [4:0] dir, input logic [31:0] data,
                            input logic rdy, input logic [4:0] saddr);
    logic cap;
    m_rst = rst;
    if (rst) begin
      exp_q.delete();
      m_seq  = 8'd0;
      m_ovf  = 1'b0;
      m_drop = 8'd0;
      for (int i = 0; i < 32; i++) m_sh[i] = 32'd0;
      m_shd  = 32'd0;
    end else begin
      cap = (pc >= PC_START) && !wr && (dir != 5'd0);
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (cap) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({dir, data, m_seq});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
        end
        m_seq = m_seq + 8'd1;
        m_sh[dir] = data;
      end
      m_shd = m_sh[saddr];
    end
  endtask

  task automatic check_model();
    logic [44:0] head;
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("trc_valid", 32'(trc_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("trc_dir", 32'(trc_dir), 32'(head[44:40]));
      chk("trc_data", trc_data, head[39:8]);
      chk("trc_seq", 32'(trc_seq), 32'(head[7:0]));
    end else if (m_rst) begin
      chk("trc_dir_rst", 32'(trc_dir), 32'd0);
      chk("trc_data_rst", trc_data, 32'd0);
      chk("trc_seq_rst", 32'(trc_seq), 32'd0);
    end
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("shadow_data", shadow_data, m_shd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rst, input logic [31:0] pc, input logic wr,
                       input logic [4:0] dir, input logic [31:0] di, input logic [31:0] dod,
                       input logic rdy, input logic [4:0] saddr);
    resetM = rst; P_C = pc; REG_WR = wr; DIR_WRA = dir;
    DI_banco = di; DO_D = dod; trc_ready = rdy; shadow_addr = saddr;
    model_step(rst, pc, wr, dir, di | dod, rdy, saddr);
    @(posedge reloj);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic do_reset();
    cycle(1'b1, 32'd0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic capture(input logic [4:0] dir, input logic [31:0] data, input logic rdy);
    cycle(1'b0, 32'd100, 1'b0, dir, data, 32'd0, rdy, 5'd0);
  endtask

  task automatic idle(input logic rdy, input logic [4:0] saddr);
    cycle(1'b0, 32'd100, 1'b1, 5'd0, 32'd0, 32'd0, rdy, saddr);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        wr;
    logic [4:0]  dir;
    logic [31:0] di;
    logic [31:0] dod;
    logic        rdy;
    logic [4:0]  saddr;
    int          e_count;
    logic        e_valid;
    logic [4:0]  e_dir;
    logic [31:0] e_data;
    logic [7:0]  e_seq;
    logic        e_ovf;
    logic [7:0]  e_drop;
    logic [31:0] e_sh;
  } vec_t;

  vec_t vecs[7];

  initial begin
    resetM = 1'b1; P_C = '0; REG_WR = 1'b1; DIR_WRA = '0;
    DI_banco = '0; DO_D = '0; trc_ready = 1'b0; shadow_addr = '0;
    m_rst = 1'b1; m_seq = '0; m_ovf = 1'b0; m_drop = '0; m_shd = '0;
    for (int i = 0; i < 32; i++) m_sh[i] = '0;

    //          rst pc      wr dir  di        dod       rdy sad  cnt vld dir data      seq ovf drop sh
    vecs[0] = '{1, 32'd0,  1, 5'd0, 32'h0,    32'h0,    0, 5'd0, 0, 0, 5'd0, 32'h0,  8'd0, 0, 8'd0, 32'h0};
    vecs[1] = '{0, 32'd8,  0, 5'd3, 32'h1,    32'h0,    1, 5'd0, 0, 0, 5'd0, 32'h0,  8'd0, 0, 8'd0, 32'h0};
    vecs[2] = '{0, 32'd12, 0, 5'd3, 32'hF0,   32'h0F,   0, 5'd3, 1, 1, 5'd3, 32'hFF, 8'd0, 0, 8'd0, 32'hFF};
    vecs[3] = '{0, 32'd20, 0, 5'd0, 32'h55,   32'h0,    0, 5'd0, 1, 1, 5'd3, 32'hFF, 8'd0, 0, 8'd0, 32'h0};
    vecs[4] = '{0, 32'd20, 1, 5'd5, 32'h66,   32'h0,    0, 5'd5, 1, 1, 5'd3, 32'hFF, 8'd0, 0, 8'd0, 32'h0};
    vecs[5] = '{0, 32'd20, 0, 5'd4, 32'h1,    32'h2,    1, 5'd3, 1, 1, 5'd4, 32'h3,  8'd1, 0, 8'd0, 32'hFF};
    vecs[6] = '{0, 32'd20, 1, 5'd0, 32'h0,    32'h0,    1, 5'd4, 0, 0, 5'd0, 32'h0,  8'd0, 0, 8'd0, 32'h3};

    for (int v = 0; v < 7; v++) begin
      cycle(vecs[v].rst, vecs[v].pc, vecs[v].wr, vecs[v].dir, vecs[v].di, vecs[v].dod,
            vecs[v].rdy, vecs[v].saddr);
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].e_count));
      chk($sformatf("vec%0d_valid", v), 32'(trc_valid), 32'(vecs[v].e_valid));
      if (vecs[v].e_valid) begin
        chk($sformatf("vec%0d_dir", v), 32'(trc_dir), 32'(vecs[v].e_dir));
        chk($sformatf("vec%0d_data", v), trc_data, vecs[v].e_data);
        chk($sformatf("vec%0d_seq", v), 32'(trc_seq), 32'(vecs[v].e_seq));
      end
      chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].e_ovf));
      chk($sformatf("vec%0d_drop", v), 32'(drop_cnt), 32'(vecs[v].e_drop));
      chk($sformatf("vec%0d_shadow", v), shadow_data, vecs[v].e_sh);
    end

    // Overflow: 10 captures into 8 slots, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) capture(5'(i % 31 + 1), $urandom, 1'b0);
    chk("ovf10_count", 32'(count), 32'd8);
    chk("ovf10_ovf", 32'(ovf), 32'd1);
    chk("ovf10_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 32'(trc_seq), 32'(i));
      idle(1'b1, 5'd0);
    end
    chk("drain_empty", 32'(trc_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with a simultaneous pop keeps the new capture.
    do_reset();
    for (int i = 0; i < 8; i++) capture(5'd2, 32'(i), 1'b0);
    capture(5'd9, 32'hABC, 1'b1);
    chk("fullpop_count", 32'(count), 32'd8);
    chk("fullpop_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("fullpop_last_data", trc_data, 32'hABC);
        chk("fullpop_last_seq", 32'(trc_seq), 32'd8);
      end
      idle(1'b1, 5'd0);
    end

    // Shadow write-first, then reset with entries queued.
    do_reset();
    cycle(1'b0, 32'd40, 1'b0, 5'd7, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 5'd7);
    chk("shadow_wf", shadow_data, 32'hDEAD_BEEF);
    for (int i = 1; i <= 3; i++) capture(5'(i), 32'(i * 16), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd4);
    cycle(1'b1, 32'd40, 1'b0, 5'd7, 32'h1, 32'h0, 1'b1, 5'd7);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(trc_valid), 32'd0);
    idle(1'b0, 5'd7);
    chk("rst_shadow7", shadow_data, 32'd0);

    // Drop counter saturation and sequence wrap.
    do_reset();
    for (int i = 0; i < 270; i++) capture(5'($urandom_range(1, 31)), $urandom, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd8);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int thr;
      thr = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 55 : 85);
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom,
            ($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'd0,
            ($urandom_range(0, 99) < thr),
            5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
